// File: rtl/mem_stream_loader.sv
// Streams a little-endian program image (word count, then words) into data memory and holds the CPU
// in reset until the image is written. Define LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte.
module mem_stream_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        io_start,
    input  logic        io_byte_valid,
    input  logic [7:0]  io_byte_data,
    output logic        io_byte_ready,
    output logic [31:0] io_datamem_addr,
    output logic        io_datamem_wen,
    output logic [31:0] io_datamem_wdata,
    output logic        io_cpu_hold,
    output logic        io_busy,
    output logic        io_done,
    output logic        io_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    // State entered once the last word (or an empty header) has been consumed.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CSUM;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t      state_q, state_d;
    logic [23:0] shift_q, shift_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] nwords_q, nwords_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wen_q, wen_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        fire;
    logic [31:0] word;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bcnt_d   = bcnt_q;
        nwords_d = nwords_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wen_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        fire = io_byte_valid && ready_q;
        // Bytes arrive LSB first, so each new byte lands in the top lane.
        word = {io_byte_data, shift_q};
        if (fire) begin
            shift_d = word[31:8];
            bcnt_d  = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = csum_q + io_byte_data;
`endif
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (io_start) begin
                    state_d  = S_LEN;
                    bcnt_d   = 2'd0;
                    idx_d    = 32'd0;
                    nwords_d = 32'd0;
                    addr_d   = BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                    csum_d   = 8'd0;
`endif
                end
            end
            S_LEN: begin
                if (fire && bcnt_q == 2'd3) begin
                    nwords_d = word;
                    if (word > 32'(MAX_WORDS))
                        state_d = S_ERR;
                    else if (word == 32'd0)
                        state_d = S_FIN;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (fire && bcnt_q == 2'd3) begin
                    state_d = S_WRITE;
                    wen_d   = 1'b1;
                    addr_d  = BASE_ADDR + {idx_q[29:0], 2'b00};
                    wdata_d = word;
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + 32'd1;
                state_d = (idx_d == nwords_q) ? S_FIN : S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (fire)
                    state_d = (io_byte_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered as a function of the next state.
        ready_d = (state_d == S_LEN) || (state_d == S_DATA);
`ifdef LOADER_CHECKSUM_EN
        ready_d = ready_d || (state_d == S_CSUM);
`endif
        busy_d  = ready_d || (state_d == S_WRITE);
        hold_d  = (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bcnt_q   <= '0;
            nwords_q <= '0;
            idx_q    <= '0;
            addr_q   <= BASE_ADDR;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bcnt_q   <= bcnt_d;
            nwords_q <= nwords_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wen_q    <= wen_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            error_q  <= error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign io_byte_ready    = ready_q;
    assign io_datamem_addr  = addr_q;
    assign io_datamem_wen   = wen_q;
    assign io_datamem_wdata = wdata_q;
    assign io_cpu_hold      = hold_q;
    assign io_busy          = busy_q;
    assign io_done          = done_q;
    assign io_error         = error_q;

endmodule

// File: tb/tb_mem_stream_loader.sv
// Bench for mem_stream_loader: directed and randomized image loads checked against a queue-based
// model of the stream format and the expected memory writes.
module tb_mem_stream_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        bvalid;
    logic [7:0]  bdata;
    logic        bready;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic        hold;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    logic prev_wen = 1'b0;
    logic [63:0] wq[$];

    always #5 clk = ~clk;

    mem_stream_loader dut (
        .clock           (clk),
        .reset_n         (rst_n),
        .io_start        (start),
        .io_byte_valid   (bvalid),
        .io_byte_data    (bdata),
        .io_byte_ready   (bready),
        .io_datamem_addr (addr),
        .io_datamem_wen  (wen),
        .io_datamem_wdata(wdata),
        .io_cpu_hold     (hold),
        .io_busy         (busy),
        .io_done         (done),
        .io_error        (error)
    );

    // Write log plus protocol invariants: ready low on every write cycle, single-cycle strobes,
    // and hold released exactly while done is up.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (wen === 1'b1) begin
                wq.push_back({addr, wdata});
                if (bready !== 1'b0) viol++;
                if (prev_wen === 1'b1) viol++;
            end
            if (done === hold) viol++;
        end
        prev_wen = wen;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int t = 0;
        if (rnd) begin
            while ($urandom_range(0, 2) == 0) begin
                bvalid = 1'b0;
                start  = ($urandom_range(0, 4) == 0);
                @(negedge clk);
            end
        end
        start  = 1'b0;
        bvalid = 1'b1;
        bdata  = b;
        while (bready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("byte_accept_timeout", 32'(t < 50), 32'd1);
        @(negedge clk);
        bvalid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load(input logic [31:0] hdr, input logic [31:0] w[$], input bit rnd,
                        input logic [7:0] cs_err);
        logic [7:0]  s[$];
        logic [7:0]  sum;
        logic [31:0] v;
        bit          ok;
        int          nexp;
        int          t;
        sum = 8'd0;
        for (int b = 0; b < 4; b++) s.push_back(hdr[8*b +: 8]);
        for (int i = 0; i < w.size(); i++) begin
            v = w[i];
            for (int b = 0; b < 4; b++) s.push_back(v[8*b +: 8]);
        end
        foreach (s[k]) sum = sum + s[k];
`ifdef LOADER_CHECKSUM_EN
        if (hdr <= 32'd4096) s.push_back(sum + cs_err);
        ok = (hdr <= 32'd4096) && (cs_err == 8'd0);
`else
        ok = (hdr <= 32'd4096);
`endif
        nexp = (hdr <= 32'd4096) ? w.size() : 0;

        wq.delete();
        pulse_start();
        chk("start_busy", busy, 1);
        chk("start_hold", hold, 1);
        chk("start_done_clr", done, 0);
        chk("start_err_clr", error, 0);
        foreach (s[k]) begin
            send_byte(s[k], rnd);
            if (k >= 4 && k < 4 + 4 * nexp && ((k - 4) % 4) == 3) begin
                chk("wen_latency", wen, 1);
                chk("ready_in_write", bready, 0);
            end
        end
        t = 0;
        while (done !== 1'b1 && error !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("end_timeout", 32'(t < 100), 32'd1);
        chk("end_done", done, 32'(ok));
        chk("end_error", error, 32'(!ok));
        chk("end_hold", hold, 32'(!ok));
        chk("end_busy", busy, 0);
        chk("write_count", wq.size(), nexp);
        for (int i = 0; i < nexp && i < wq.size(); i++) begin
            chk("write_addr", wq[i][63:32], 32'(4 * i));
            chk("write_data", wq[i][31:0], w[i]);
        end
    endtask

    initial begin
        logic [31:0] w2[$];
        logic [31:0] wr[$];
        logic [31:0] nil[$];
        logic [7:0]  pre[$];
        rst_n  = 1'b0;
        start  = 1'b0;
        bvalid = 1'b0;
        bdata  = 8'h00;
        w2 = '{32'h0000_0013, 32'h0010_0093};
        pre = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};

        // Reset values, then idle with no start.
        repeat (2) @(negedge clk);
        chk("rst_hold", hold, 1);
        chk("rst_wen", wen, 0);
        chk("rst_ready", bready, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_ready", bready, 0);
            chk("idle_hold", hold, 1);
        end
        chk("idle_nowrite", wq.size(), 0);

        // Reference two-word image, directed then with random stalls.
        load(32'd2, w2, 1'b0, 8'd0);
        load(32'd2, w2, 1'b1, 8'd0);

        // Random images with random valid gaps and ignored mid-load starts.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 8);
            wr.delete();
            for (int i = 0; i < n; i++) wr.push_back($urandom());
            load(32'(n), wr, 1'b1, 8'd0);
        end

        // Oversized header, then an empty image.
        load(32'd4097, nil, 1'b0, 8'd0);
        load(32'd0, nil, 1'b0, 8'd0);

        // Reset in the middle of a load, then a clean reload.
        wq.delete();
        pulse_start();
        foreach (pre[k]) send_byte(pre[k], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_wen", wen, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_hold", hold, 1);
        chk("midrst_ready", bready, 0);
        chk("midrst_addr", addr, 0);
        chk("midrst_nowrite", wq.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load(32'd2, w2, 1'b0, 8'd0);

`ifdef LOADER_CHECKSUM_EN
        // Wrong trailing byte: words still written, load flagged as failed.
        load(32'd2, w2, 1'b0, 8'd1);
`endif

        chk("protocol_violations", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
